// File: rtl/ide_pkg.sv
// ide_pkg: shared types and constants for the IDE PIO controller.
//   - ide_state_t : transfer FSM states
//   - DEF_T_*     : default phase timings in clk cycles
//   - CS_SEL_*    : one-hot chip-select encodings found in addr[4:3]
//   - REG_*       : ATA task-file register offsets found in addr[2:0]
//   - cs_sel_valid: true when exactly one chip select is requested
package ide_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } ide_state_t;

  localparam int DEF_T_SETUP    = 3;
  localparam int DEF_T_STROBE   = 8;
  localparam int DEF_T_HOLD     = 2;
  localparam int DEF_T_WAIT_MAX = 255;

  localparam logic [1:0] CS_SEL_CS0 = 2'b01;
  localparam logic [1:0] CS_SEL_CS1 = 2'b10;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_ERROR   = 3'd1;
  localparam logic [2:0] REG_NSECT   = 3'd2;
  localparam logic [2:0] REG_LBA0    = 3'd3;
  localparam logic [2:0] REG_LBA1    = 3'd4;
  localparam logic [2:0] REG_LBA2    = 3'd5;
  localparam logic [2:0] REG_DEVHEAD = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  function automatic logic cs_sel_valid(input logic [1:0] sel);
    return (sel == CS_SEL_CS0) || (sel == CS_SEL_CS1);
  endfunction

endpackage

// File: rtl/ide_phase_timer.sv
// ide_phase_timer: loadable down-counter with a zero flag.
//   clk, reset_n : clock, synchronous active-low reset (count clears to 0)
//   load         : load load_val this cycle (has priority over counting)
//   en           : decrement when nonzero
//   load_val     : value to load
//   zero         : count is zero
module ide_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ide_pio_ctrl.sv
// ide_pio_ctrl: ATA/IDE PIO bus controller with programmable setup/strobe/hold.
// Optional feature macro: IDE_IORDY_EN (adds ide_iordy strobe extension + timeout).
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   req, we, addr     : host request (level), direction, {cs_sel[1:0], da[2:0]}
//   wdata, rdata      : host write data / captured read data (held until next read)
//   ack               : one-cycle completion pulse
//   busy              : controller is not IDLE
//   err               : sticky IORDY timeout flag (0 without IDE_IORDY_EN)
//   ide_data_bus      : IDE data lines (driven only during a write transfer)
//   ide_dior/ide_diow : active-low read/write strobes
//   ide_cs, ide_da    : active-low chip selects, device address
//   ide_iordy         : device ready (only with IDE_IORDY_EN)
//
// Handshake: the host raises req with we/addr/wdata stable and keeps it high until
// ack. A request is accepted only in IDLE and only if req has been seen low in IDLE
// since the previous acceptance, so a req still high at ack starts no second
// transfer. Dropping req mid-transfer does not abort it.
module ide_pio_ctrl
  import ide_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int T_SETUP    = DEF_T_SETUP,
  parameter int T_STROBE   = DEF_T_STROBE,
  parameter int T_HOLD     = DEF_T_HOLD,
  parameter int CNT_W      = 4,
  parameter int T_WAIT_MAX = DEF_T_WAIT_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err,
  inout  wire  [DATA_W-1:0] ide_data_bus,
  output logic              ide_dior,
  output logic              ide_diow,
  output logic [1:0]        ide_cs,
  output logic [2:0]        ide_da
`ifdef IDE_IORDY_EN
  ,
  input  logic              ide_iordy
`endif
);

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);

  ide_state_t        state, state_n;
  logic              we_q;
  logic [4:0]        addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              armed;
  logic              accept;
  logic              leave_strobe;
  logic              ph_load;
  logic [CNT_W-1:0]  ph_val;
  logic              ph_zero;
  logic              bus_oe;
  logic [1:0]        cs_drive;

  assign accept = (state == ST_IDLE) && req && armed;

  ide_phase_timer #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ph_load),
    .en       (1'b1),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

`ifdef IDE_IORDY_EN
  localparam int WAIT_W = (T_WAIT_MAX < 1) ? 1 : $clog2(T_WAIT_MAX + 1);

  logic wt_load;
  logic wt_en;
  logic wt_zero;
  logic timeout;
  logic err_q;

  // The wait budget is armed on STROBE entry and only spent on cycles where the
  // minimum strobe has elapsed and the device is still holding IORDY low.
  assign wt_load = (state == ST_SETUP) && ph_zero;
  assign wt_en   = (state == ST_STROBE) && ph_zero && !ide_iordy;
  assign timeout = wt_en && wt_zero;

  ide_phase_timer #(.CNT_W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (wt_load),
    .en       (wt_en),
    .load_val (WAIT_W'(T_WAIT_MAX)),
    .zero     (wt_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; the phase timer is loaded on the edge that enters a phase.
  always_comb begin
    state_n      = state;
    ph_load      = 1'b0;
    ph_val       = '0;
    leave_strobe = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_SETUP;
          ph_load = 1'b1;
          ph_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_zero) begin
          state_n = ST_STROBE;
          ph_load = 1'b1;
          ph_val  = LD_STROBE;
        end
      end
      ST_STROBE: begin
`ifdef IDE_IORDY_EN
        leave_strobe = ph_zero && (ide_iordy || wt_zero);
`else
        leave_strobe = ph_zero;
`endif
        if (leave_strobe) begin
          state_n = ST_HOLD;
          ph_load = 1'b1;
          ph_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (ph_zero) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Request latch, re-arm tracking and read capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      armed   <= 1'b1;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        armed   <= 1'b0;
      end else if ((state == ST_IDLE) && !req) begin
        armed <= 1'b1;
      end
      // With no valid chip select no device answers; the board pull-ups make the
      // bus read as all-ones, so return that value deterministically.
      if (leave_strobe && !we_q) begin
        rdata_q <= cs_sel_valid(addr_q[4:3]) ? ide_data_bus : '1;
      end
    end
  end

  assign cs_drive = cs_sel_valid(addr_q[4:3]) ? ~addr_q[4:3] : 2'b11;

  // Output logic
  always_comb begin
    busy     = (state != ST_IDLE);
    ack      = (state == ST_DONE);
    ide_dior = 1'b1;
    ide_diow = 1'b1;
    ide_cs   = 2'b11;
    ide_da   = 3'd0;
    bus_oe   = 1'b0;
    case (state)
      ST_SETUP, ST_HOLD: begin
        ide_cs = cs_drive;
        ide_da = addr_q[2:0];
        bus_oe = we_q;
      end
      ST_STROBE: begin
        ide_cs   = cs_drive;
        ide_da   = addr_q[2:0];
        bus_oe   = we_q;
        ide_dior = we_q;
        ide_diow = !we_q;
      end
      default: begin
      end
    endcase
  end

  assign ide_data_bus = bus_oe ? wdata_q : {DATA_W{1'bz}};
  assign rdata        = rdata_q;

  // Zero-length phases would load an underflowed count; each phase load value
  // and the IORDY budget must fit their counters.
  param_check: assert property (@(posedge clk) disable iff (!reset_n)
    (T_SETUP >= 1) && (T_STROBE >= 1) && (T_HOLD >= 1) &&
    (T_SETUP - 1 < (1 << CNT_W)) && (T_STROBE - 1 < (1 << CNT_W)) &&
    (T_HOLD - 1 < (1 << CNT_W)) && (T_WAIT_MAX >= 0) && (T_WAIT_MAX < 65536) &&
    ((DATA_W == 8) || (DATA_W == 16)));

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// tb_ide_pio_ctrl: self-checking bench for ide_pio_ctrl (default and 8-bit fast
// instances). IORDY scenarios are included when IDE_IORDY_EN is defined.
module tb_ide_pio_ctrl;

  localparam int TS      = 3;
  localparam int TST     = 8;
  localparam int TH      = 2;
  localparam int TWMAX   = 255;
  localparam int EXP_ACK = TS + TST + TH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance ----------------
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack, busy, err;
  wire  [15:0] bus;
  logic        dior, diow;
  logic [1:0]  cs;
  logic [2:0]  da;
  logic [15:0] dev_data = '0;
`ifdef IDE_IORDY_EN
  logic        iordy = 1'b1;
`endif

  // Device model: answers a read strobe when one chip select is active.
  assign bus = (!dior && (cs != 2'b11)) ? dev_data : 16'hzzzz;

  ide_pio_ctrl dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err),
    .ide_data_bus(bus), .ide_dior(dior), .ide_diow(diow), .ide_cs(cs), .ide_da(da)
`ifdef IDE_IORDY_EN
    , .ide_iordy(iordy)
`endif
  );

  // ---------------- 8-bit fast instance ----------------
  logic       req8 = 1'b0;
  logic       we8 = 1'b0;
  logic [4:0] addr8 = '0;
  logic [7:0] wdata8 = '0;
  logic [7:0] rdata8;
  logic       ack8, busy8, err8;
  wire  [7:0] bus8;
  logic       dior8, diow8;
  logic [1:0] cs8;
  logic [2:0] da8;
  logic [7:0] dev8 = '0;

  assign bus8 = (!dior8 && (cs8 != 2'b11)) ? dev8 : 8'hzz;

  ide_pio_ctrl #(.DATA_W(8), .T_SETUP(1), .T_STROBE(2), .T_HOLD(1), .CNT_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .req(req8), .we(we8), .addr(addr8),
    .wdata(wdata8), .rdata(rdata8), .ack(ack8), .busy(busy8), .err(err8),
    .ide_data_bus(bus8), .ide_dior(dior8), .ide_diow(diow8), .ide_cs(cs8), .ide_da(da8)
`ifdef IDE_IORDY_EN
    , .ide_iordy(1'b1)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // Observations from the last do_xfer
  int          obs_ack_idx, obs_ack_cnt, obs_rd_lo, obs_wr_lo;
  logic [15:0] obs_rdata, obs_bus_first, obs_bus_last;
  logic [1:0]  obs_cs_mid, obs_cs_done;
  logic [2:0]  obs_da_mid;
  logic        obs_busy_end;

  // Reference model: chip-select pins for a requested select field.
  function automatic logic [1:0] model_cs(input logic [1:0] sel);
    case (sel)
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [15:0] model_rd(input logic [1:0] sel, input logic [15:0] dd);
    return (model_cs(sel) == 2'b11) ? 16'hFFFF : dd;
  endfunction

  // ---------------- driver / monitor ----------------
  // Issues one request and watches win cycles from the acceptance edge (cycle 0).
  task automatic do_xfer(input logic w, input logic [4:0] a, input logic [15:0] wd,
                         input logic [15:0] dd, input bit hold, input int pulse_n,
                         input int lo_from, input int lo_to, input int win);
    dev_data = dd;
    @(negedge clk);
    we = w; addr = a; wdata = wd; req = 1'b1;
    obs_ack_idx = -1; obs_ack_cnt = 0; obs_rd_lo = 0; obs_wr_lo = 0;
    obs_rdata = 'x; obs_bus_first = 'x; obs_bus_last = 'x;
    obs_cs_mid = 'x; obs_cs_done = 'x; obs_da_mid = 'x;
    for (int n = 0; n < win; n++) begin
      @(negedge clk);
      if (!dior) obs_rd_lo++;
      if (!diow) begin
        if (obs_wr_lo == 0) obs_bus_first = bus;
        obs_bus_last = bus;
        obs_wr_lo++;
      end
      if (n == 1) begin
        obs_cs_mid = cs;
        obs_da_mid = da;
      end
      if (ack) begin
        if (obs_ack_idx < 0) obs_ack_idx = n;
        obs_ack_cnt++;
        obs_rdata = rdata;
        obs_cs_done = cs;
      end
      if (!hold && (n == 0)) req = 1'b0;
      if (n == pulse_n) req = 1'b1;
      if (n == pulse_n + 1) req = 1'b0;
`ifdef IDE_IORDY_EN
      iordy = !((n + 1 >= lo_from) && (n + 1 <= lo_to));
`endif
    end
    obs_busy_end = busy;
    req = 1'b0;
`ifdef IDE_IORDY_EN
    iordy = 1'b1;
`endif
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if ({dior, diow} !== 2'b11) begin n_fail++; $display("FAIL rst_strobes: got %b want 11", {dior, diow}); end
    n_cmp++; if (cs !== 2'b11) begin n_fail++; $display("FAIL rst_cs: got %b want 11", cs); end
    n_cmp++; if (da !== 3'd0) begin n_fail++; $display("FAIL rst_da: got %0d want 0", da); end
    n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
  endtask

  task automatic test_write();
    do_xfer(1'b1, 5'b01_000, 16'hA55A, 16'h0000, 1'b0, -10, -1, -1, 20);
    n_cmp++; if (obs_ack_idx !== EXP_ACK) begin n_fail++; $display("FAIL wr_ack_idx: got %0d want %0d", obs_ack_idx, EXP_ACK); end
    n_cmp++; if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL wr_ack_width: got %0d want 1", obs_ack_cnt); end
    n_cmp++; if (obs_wr_lo !== TST) begin n_fail++; $display("FAIL wr_diow_len: got %0d want %0d", obs_wr_lo, TST); end
    n_cmp++; if (obs_rd_lo !== 0) begin n_fail++; $display("FAIL wr_dior_len: got %0d want 0", obs_rd_lo); end
    n_cmp++; if (obs_cs_mid !== 2'b10) begin n_fail++; $display("FAIL wr_cs: got %b want 10", obs_cs_mid); end
    n_cmp++; if (obs_da_mid !== 3'd0) begin n_fail++; $display("FAIL wr_da: got %0d want 0", obs_da_mid); end
    n_cmp++; if (obs_bus_first !== 16'hA55A) begin n_fail++; $display("FAIL wr_bus_first: got %h want a55a", obs_bus_first); end
    n_cmp++; if (obs_bus_last !== 16'hA55A) begin n_fail++; $display("FAIL wr_bus_last: got %h want a55a", obs_bus_last); end
    n_cmp++; if (obs_cs_done !== 2'b11) begin n_fail++; $display("FAIL wr_cs_done: got %b want 11", obs_cs_done); end
  endtask

  task automatic test_read();
    do_xfer(1'b0, 5'b10_111, 16'h0000, 16'h1234, 1'b0, -10, -1, -1, 20);
    n_cmp++; if (obs_ack_idx !== EXP_ACK) begin n_fail++; $display("FAIL rd_ack_idx: got %0d want %0d", obs_ack_idx, EXP_ACK); end
    n_cmp++; if (obs_rd_lo !== TST) begin n_fail++; $display("FAIL rd_dior_len: got %0d want %0d", obs_rd_lo, TST); end
    n_cmp++; if (obs_cs_mid !== 2'b01) begin n_fail++; $display("FAIL rd_cs: got %b want 01", obs_cs_mid); end
    n_cmp++; if (obs_da_mid !== 3'd7) begin n_fail++; $display("FAIL rd_da: got %0d want 7", obs_da_mid); end
    n_cmp++; if (obs_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_rdata: got %h want 1234", obs_rdata); end
  endtask

  task automatic test_no_cs();
    do_xfer(1'b0, 5'b00_010, 16'h0000, 16'h5555, 1'b0, -10, -1, -1, 20);
    n_cmp++; if (obs_cs_mid !== 2'b11) begin n_fail++; $display("FAIL nocs00_cs: got %b want 11", obs_cs_mid); end
    n_cmp++; if (obs_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL nocs00_rdata: got %h want ffff", obs_rdata); end
    do_xfer(1'b0, 5'b11_101, 16'h0000, 16'h5555, 1'b0, -10, -1, -1, 20);
    n_cmp++; if (obs_cs_mid !== 2'b11) begin n_fail++; $display("FAIL nocs11_cs: got %b want 11", obs_cs_mid); end
    n_cmp++; if (obs_ack_idx !== EXP_ACK) begin n_fail++; $display("FAIL nocs11_ack: got %0d want %0d", obs_ack_idx, EXP_ACK); end
    n_cmp++; if (obs_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL nocs11_rdata: got %h want ffff", obs_rdata); end
  endtask

  task automatic test_handshake();
    // req held high well past ack: one transfer only
    do_xfer(1'b0, 5'b01_011, 16'h0000, 16'hBEEF, 1'b1, -10, -1, -1, 2 * EXP_ACK);
    n_cmp++; if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL hs_hold_acks: got %0d want 1", obs_ack_cnt); end
    n_cmp++; if (obs_busy_end !== 1'b0) begin n_fail++; $display("FAIL hs_hold_busy: got %b want 0", obs_busy_end); end
    n_cmp++; if (obs_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL hs_hold_rdata: got %h want beef", obs_rdata); end
    // second req pulsed while busy: ignored
    do_xfer(1'b1, 5'b10_001, 16'h0F0F, 16'h0000, 1'b0, 5, -1, -1, 2 * EXP_ACK);
    n_cmp++; if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL hs_pulse_acks: got %0d want 1", obs_ack_cnt); end
    n_cmp++; if (obs_ack_idx !== EXP_ACK) begin n_fail++; $display("FAIL hs_pulse_idx: got %0d want %0d", obs_ack_idx, EXP_ACK); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] last_rd;
    logic [1:0]  sel;
    logic        w;
    logic [2:0]  dsel;
    logic [15:0] wd, dd, got;
    last_rd = 'x;
    for (int t = 0; t < 16; t++) begin
      w    = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      dsel = 3'($urandom_range(0, 7));
      wd   = 16'($urandom);
      dd   = 16'($urandom);
      if (!w) last_rd = model_rd(sel, dd);
      exp_q.push_back(last_rd);
      do_xfer(w, {sel, dsel}, wd, dd, 1'b0, -10, -1, -1, EXP_ACK + 3);
      got = exp_q.pop_front();
      n_cmp++; if (obs_rdata !== got) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", t, obs_rdata, got); end
      n_cmp++; if (obs_ack_idx !== EXP_ACK) begin n_fail++; $display("FAIL rnd%0d_ack: got %0d want %0d", t, obs_ack_idx, EXP_ACK); end
      n_cmp++; if (obs_cs_mid !== model_cs(sel)) begin n_fail++; $display("FAIL rnd%0d_cs: got %b want %b", t, obs_cs_mid, model_cs(sel)); end
      n_cmp++; if (obs_da_mid !== dsel) begin n_fail++; $display("FAIL rnd%0d_da: got %0d want %0d", t, obs_da_mid, dsel); end
      n_cmp++; if ((w ? obs_wr_lo : obs_rd_lo) !== TST) begin n_fail++; $display("FAIL rnd%0d_strobe: got %0d want %0d", t, (w ? obs_wr_lo : obs_rd_lo), TST); end
      if (w) begin
        n_cmp++; if (obs_bus_last !== wd) begin n_fail++; $display("FAIL rnd%0d_bus: got %h want %h", t, obs_bus_last, wd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    @(negedge clk);
    we = 1'b1; addr = 5'b01_001; wdata = 16'h0F0F; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (diow !== 1'b0) begin n_fail++; $display("FAIL rmid_pre_diow: got %b want 0", diow); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({dior, diow} !== 2'b11) begin n_fail++; $display("FAIL rmid_strobes: got %b want 11", {dior, diow}); end
    n_cmp++; if (cs !== 2'b11) begin n_fail++; $display("FAIL rmid_cs: got %b want 11", cs); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack: got %b want 0", ack); end
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (EXP_ACK + 2) begin
      @(negedge clk);
      if (ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rmid_late_ack: got %0d want 0", acks); end
    n_cmp++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rmid_rdata: got %h want 0000", rdata); end
  endtask

  task automatic test_params8();
    int ack_idx, lo;
    logic [7:0] got;
    dev8 = 8'hC3;
    @(negedge clk);
    we8 = 1'b0; addr8 = 5'b01_100; req8 = 1'b1;
    ack_idx = -1; lo = 0; got = 'x;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 0) req8 = 1'b0;
      if (!dior8) lo++;
      if (ack8 && (ack_idx < 0)) begin
        ack_idx = n;
        got = rdata8;
      end
    end
    n_cmp++; if (ack_idx !== 1 + 2 + 1) begin n_fail++; $display("FAIL p8_ack_idx: got %0d want 4", ack_idx); end
    n_cmp++; if (lo !== 2) begin n_fail++; $display("FAIL p8_dior_len: got %0d want 2", lo); end
    n_cmp++; if (got !== 8'hC3) begin n_fail++; $display("FAIL p8_rdata: got %h want c3", got); end
  endtask

`ifdef IDE_IORDY_EN
  task automatic test_iordy();
    // iordy low for the last base strobe cycle and 4 more: 5 extra strobe cycles
    do_xfer(1'b0, 5'b01_000, 16'h0000, 16'h0BAD, 1'b0, -10, TS + TST - 1, TS + TST + 3, 30);
    n_cmp++; if (obs_rd_lo !== TST + 5) begin n_fail++; $display("FAIL io_dior_len: got %0d want %0d", obs_rd_lo, TST + 5); end
    n_cmp++; if (obs_ack_idx !== EXP_ACK + 5) begin n_fail++; $display("FAIL io_ack_idx: got %0d want %0d", obs_ack_idx, EXP_ACK + 5); end
    n_cmp++; if (obs_rdata !== 16'h0BAD) begin n_fail++; $display("FAIL io_rdata: got %h want 0bad", obs_rdata); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL io_err: got %b want 0", err); end
    // iordy stuck low: timeout after TWMAX extra cycles, ack still issued
    do_xfer(1'b0, 5'b01_000, 16'h0000, 16'h0BAD, 1'b0, -10, TS + TST - 1, 100000, EXP_ACK + TWMAX + 10);
    n_cmp++; if (obs_rd_lo !== TST + TWMAX) begin n_fail++; $display("FAIL to_dior_len: got %0d want %0d", obs_rd_lo, TST + TWMAX); end
    n_cmp++; if (obs_ack_idx !== EXP_ACK + TWMAX) begin n_fail++; $display("FAIL to_ack_idx: got %0d want %0d", obs_ack_idx, EXP_ACK + TWMAX); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    do_xfer(1'b1, 5'b10_000, 16'h1111, 16'h0000, 1'b0, -10, -1, -1, 20);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", err); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_no_cs();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_params8();
`ifdef IDE_IORDY_EN
    test_iordy();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
